// File: rtl/i2c_mem_port.sv
// i2c_mem_port: byte-level register-file backend for an I2C subordinate.
// A write transfer first loads a PTR_BYTES-wide register pointer (MSB byte first), then
// writes data bytes at the pointer with auto-increment. A read transfer returns bytes from
// the current pointer with auto-increment. The pointer either wraps or saturates at the end
// of the array. An optional window of locations can be write-protected.
//
// Ports:
//   clk, rst_n          system clock, asynchronous active-low reset
//   start_det/stop_det  bus condition strobes from the protocol engine
//   addr_match_wr/rd    own-address match strobes with the R/W direction
//   rx_valid/rx_data    received byte strobe and data
//   rx_ack_valid/rx_ack ACK/NACK decision, one clock after each accepted byte
//   tx_req/master_nack  master ACKed (next byte wanted) / NACKed the last read byte
//   tx_valid/tx_data    next byte to shift out
//   wp_en/wp_violation  write-protect enable and blocked-write pulse
//   busy, ptr           status: not idle, current register pointer
module i2c_mem_port #(
  parameter int unsigned DEPTH     = 128,
  parameter int unsigned PTR_BYTES = 1,
  parameter bit          WRAP      = 1'b1,
  parameter int unsigned WP_BASE   = 0,
  parameter int unsigned WP_LIMIT  = 15,
  localparam int unsigned PTR_W    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_det,
  input  logic             stop_det,
  input  logic             addr_match_wr,
  input  logic             addr_match_rd,
  input  logic             rx_valid,
  input  logic [7:0]       rx_data,
  output logic             rx_ack_valid,
  output logic             rx_ack,
  input  logic             tx_req,
  input  logic             master_nack,
  output logic             tx_valid,
  output logic [7:0]       tx_data,
  input  logic             wp_en,
  output logic             wp_violation,
  output logic             busy,
  output logic [PTR_W-1:0] ptr
);

  localparam int unsigned     SW      = 8 * PTR_BYTES;
  localparam logic [PTR_W-1:0] PTR_MAX = PTR_W'(DEPTH - 1);
  localparam logic [1:0]       LAST_PB = 2'(PTR_BYTES - 1);

  typedef enum logic [2:0] {StIdle, StPtr, StWrite, StRdFetch, StRdHold} state_e;

  state_e           r_state, w_state_d;
  logic [PTR_W-1:0] r_ptr, w_ptr_d, w_adv_ptr;
  logic             r_end, w_end_d, w_adv_end;
  logic [1:0]       r_pcnt, w_pcnt_d;
  logic [SW-1:0]    r_stage, w_stage_d, w_stage_sh;
  logic             r_fetch, w_fetch_d;
  logic             r_tx_valid, w_tx_valid_d;
  logic [7:0]       r_tx_data, w_tx_data_d;
  logic             r_ack_valid, w_ack_valid_d;
  logic             r_ack, w_ack_d;
  logic             r_wp_viol, w_wp_viol_d;
  logic             w_mem_we;
  logic             w_wp_hit;
  logic             w_end_stop;
  logic [7:0]       r_mem [DEPTH];
  logic [7:0]       r_rd_data;

  // Staging shifted left by one byte with the new byte appended (upper byte falls off).
  assign w_stage_sh = (r_stage << 8) | SW'(rx_data);

  // Single unsigned range check covers WP_BASE <= ptr <= WP_LIMIT.
  assign w_wp_hit   = wp_en && ((32'(r_ptr) - WP_BASE) <= (WP_LIMIT - WP_BASE));
  assign w_end_stop = !WRAP && r_end;

  // Pointer advance: wrap to 0 or hold at the end and flag it.
  always_comb begin
    w_adv_ptr = r_ptr;
    w_adv_end = r_end;
    if (r_ptr != PTR_MAX) begin
      w_adv_ptr = r_ptr + 1'b1;
    end else if (WRAP) begin
      w_adv_ptr = '0;
    end else begin
      w_adv_end = 1'b1;
    end
  end

  always_comb begin
    w_state_d     = r_state;
    w_ptr_d       = r_ptr;
    w_end_d       = r_end;
    w_pcnt_d      = r_pcnt;
    w_stage_d     = r_stage;
    w_fetch_d     = r_fetch;
    w_tx_valid_d  = 1'b0;
    w_tx_data_d   = r_tx_data;
    w_ack_valid_d = 1'b0;
    w_ack_d       = 1'b0;
    w_wp_viol_d   = 1'b0;
    w_mem_we      = 1'b0;

    if (stop_det || start_det) begin
      // Any bus condition ends the transfer; a coincident rx_valid is dropped.
      w_state_d = StIdle;
    end else if (addr_match_wr) begin
      w_state_d = StPtr;
      w_pcnt_d  = '0;
      w_stage_d = '0;
    end else if (addr_match_rd) begin
      w_state_d = StRdFetch;
      w_fetch_d = 1'b0;
    end else begin
      unique case (r_state)
        StIdle: ;
        StPtr: begin
          if (rx_valid) begin
            w_ack_valid_d = 1'b1;
            w_stage_d     = w_stage_sh;
            if (r_pcnt != LAST_PB) begin
              w_ack_d  = 1'b1;
              w_pcnt_d = r_pcnt + 2'd1;
            end else if (32'(w_stage_sh) < DEPTH) begin
              w_ack_d   = 1'b1;
              w_ptr_d   = w_stage_sh[PTR_W-1:0];
              w_end_d   = 1'b0;
              w_state_d = StWrite;
            end else begin
              w_state_d = StIdle;
            end
          end
        end
        StWrite: begin
          if (rx_valid) begin
            w_ack_valid_d = 1'b1;
            if (w_wp_hit) begin
              w_wp_viol_d = 1'b1;
            end else if (!w_end_stop) begin
              w_mem_we = 1'b1;
              w_ack_d  = 1'b1;
              w_ptr_d  = w_adv_ptr;
              w_end_d  = w_adv_end;
            end
          end
        end
        StRdFetch: begin
          // Phase 0 lets the registered array read settle; phase 1 presents the byte.
          if (!r_fetch) begin
            w_fetch_d = 1'b1;
          end else begin
            w_fetch_d    = 1'b0;
            w_tx_valid_d = 1'b1;
            w_tx_data_d  = w_end_stop ? 8'hFF : r_rd_data;
            w_ptr_d      = w_adv_ptr;
            w_end_d      = w_adv_end;
            w_state_d    = StRdHold;
          end
        end
        StRdHold: begin
          w_tx_valid_d = 1'b1;
          if (master_nack) begin
            w_tx_valid_d = 1'b0;
            w_state_d    = StIdle;
          end else if (tx_req) begin
            w_tx_valid_d = 1'b0;
            w_fetch_d    = 1'b0;
            w_state_d    = StRdFetch;
          end
        end
        default: w_state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= StIdle;
      r_ptr       <= '0;
      r_end       <= 1'b0;
      r_pcnt      <= '0;
      r_stage     <= '0;
      r_fetch     <= 1'b0;
      r_tx_valid  <= 1'b0;
      r_tx_data   <= '0;
      r_ack_valid <= 1'b0;
      r_ack       <= 1'b0;
      r_wp_viol   <= 1'b0;
    end else begin
      r_state     <= w_state_d;
      r_ptr       <= w_ptr_d;
      r_end       <= w_end_d;
      r_pcnt      <= w_pcnt_d;
      r_stage     <= w_stage_d;
      r_fetch     <= w_fetch_d;
      r_tx_valid  <= w_tx_valid_d;
      r_tx_data   <= w_tx_data_d;
      r_ack_valid <= w_ack_valid_d;
      r_ack       <= w_ack_d;
      r_wp_viol   <= w_wp_viol_d;
    end
  end

  // Storage is cleared by reset, so it is built from resettable flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
      r_rd_data <= '0;
    end else begin
      if (w_mem_we) begin
        r_mem[r_ptr] <= rx_data;
      end
      r_rd_data <= r_mem[r_ptr];
    end
  end

  assign rx_ack_valid = r_ack_valid;
  assign rx_ack       = r_ack;
  assign wp_violation = r_wp_viol;
  assign tx_valid     = r_tx_valid;
  assign tx_data      = r_tx_data;
  assign busy         = (r_state != StIdle);
  assign ptr          = r_ptr;

endmodule

// File: tb/tb_i2c_mem_port.sv
// Bench for i2c_mem_port: three instances (wrapping 1-byte pointer, saturating 1-byte
// pointer, wrapping 2-byte pointer) share one stimulus bus gated by an instance select.
// Expected values come from an array/integer model of the register file.
module tb_i2c_mem_port;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic s_start = 0, s_stop = 0, s_amw = 0, s_amr = 0, s_rxv = 0;
  logic s_txreq = 0, s_mnack = 0, s_wp = 0;
  logic [7:0] s_rxd = '0;
  logic [2:0] en = 3'b001;

  logic [2:0] o_av, o_ack, o_txv, o_wpv, o_busy;
  logic [7:0] o_txd [3];
  logic [6:0] o_ptr [3];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    i2c_mem_port #(
      .DEPTH    (128),
      .PTR_BYTES((g == 2) ? 2 : 1),
      .WRAP     (g != 1),
      .WP_BASE  (0),
      .WP_LIMIT (15)
    ) u_dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .start_det    (s_start & en[g]),
      .stop_det     (s_stop & en[g]),
      .addr_match_wr(s_amw & en[g]),
      .addr_match_rd(s_amr & en[g]),
      .rx_valid     (s_rxv & en[g]),
      .rx_data      (s_rxd),
      .rx_ack_valid (o_av[g]),
      .rx_ack       (o_ack[g]),
      .tx_req       (s_txreq & en[g]),
      .master_nack  (s_mnack & en[g]),
      .tx_valid     (o_txv[g]),
      .tx_data      (o_txd[g]),
      .wp_en        (s_wp),
      .wp_violation (o_wpv[g]),
      .busy         (o_busy[g]),
      .ptr          (o_ptr[g])
    );
  end

  // Reference model state per instance.
  int          c_pb   [3] = '{1, 1, 2};
  bit          c_wrap [3] = '{1'b1, 1'b0, 1'b1};
  int unsigned m_ptr  [3];
  bit          m_end  [3];
  int          m_phase[3];  // 0 idle/read, 1 pointer bytes, 2 data bytes
  logic [7:0]  m_mem  [3][128];
  int unsigned m_stage;
  int          m_cnt;
  int          cur;
  logic [7:0]  bq [8];
  int          n_chk = 0;
  int          n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_chk++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h (inst %0d)", tag, obs, exp_v, cur);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic sel(input int k);
    cur = k;
    en  = 3'(1 << k);
  endtask

  task automatic m_reset();
    for (int k = 0; k < 3; k++) begin
      m_ptr[k] = 0;
      m_end[k] = 1'b0;
      m_phase[k] = 0;
      for (int a = 0; a < 128; a++) m_mem[k][a] = 8'h00;
    end
  endtask

  task automatic m_adv();
    if (m_ptr[cur] == 127) begin
      if (c_wrap[cur]) m_ptr[cur] = 0;
      else m_end[cur] = 1'b1;
    end else begin
      m_ptr[cur]++;
    end
  endtask

  task automatic do_start();
    s_start = 1; step(); s_start = 0;
    m_phase[cur] = 0;
  endtask

  task automatic do_stop();
    s_stop = 1; step(); s_stop = 0;
    m_phase[cur] = 0;
    chk("busy_after_stop", 32'(o_busy[cur]), 0);
  endtask

  task automatic do_addr_wr();
    s_amw = 1; step(); s_amw = 0;
    m_phase[cur] = 1;
    m_stage = 0;
    m_cnt = 0;
    chk("busy_after_addr", 32'(o_busy[cur]), 1);
  endtask

  task automatic send_byte(input logic [7:0] b);
    bit e_av, e_ack, e_wp;
    e_av = 0; e_ack = 0; e_wp = 0;
    if (m_phase[cur] == 1) begin
      e_av = 1;
      m_stage = m_stage * 256 + b;
      m_cnt++;
      if (m_cnt < c_pb[cur]) begin
        e_ack = 1;
      end else if (m_stage < 128) begin
        e_ack = 1;
        m_ptr[cur] = m_stage;
        m_end[cur] = 1'b0;
        m_phase[cur] = 2;
      end else begin
        m_phase[cur] = 0;
      end
    end else if (m_phase[cur] == 2) begin
      e_av = 1;
      if (s_wp && (m_ptr[cur] inside {[0:15]})) begin
        e_wp = 1;
      end else if (!(!c_wrap[cur] && m_end[cur])) begin
        m_mem[cur][m_ptr[cur]] = b;
        e_ack = 1;
        m_adv();
      end
    end
    s_rxv = 1; s_rxd = b; step(); s_rxv = 0;
    chk("rx_ack_valid", 32'(o_av[cur]), 32'(e_av));
    chk("rx_ack", 32'(o_ack[cur]), 32'(e_ack));
    chk("wp_violation", 32'(o_wpv[cur]), 32'(e_wp));
    step();
    chk("rx_ack_valid_pulse", 32'(o_av[cur]), 0);
  endtask

  // Write transfer of bq[0..n-1] (pointer bytes first), optionally closed by STOP.
  task automatic wr_txn(input int n, input bit stop_end);
    do_start();
    do_addr_wr();
    for (int i = 0; i < n; i++) send_byte(bq[i]);
    if (stop_end) do_stop();
    chk("ptr_after_write", 32'(o_ptr[cur]), m_ptr[cur]);
  endtask

  // Repeated START + read of n bytes, closed by master NACK.
  task automatic rd_txn(input int n);
    logic [7:0] e_byte;
    do_start();
    s_amr = 1; step(); s_amr = 0;
    for (int i = 0; i < n; i++) begin
      chk("rd_fetch_a", 32'(o_txv[cur]), 0);
      step();
      chk("rd_fetch_b", 32'(o_txv[cur]), 0);
      step();
      e_byte = (!c_wrap[cur] && m_end[cur]) ? 8'hFF : m_mem[cur][m_ptr[cur]];
      m_adv();
      chk("rd_tx_valid", 32'(o_txv[cur]), 1);
      chk("rd_tx_data", 32'(o_txd[cur]), 32'(e_byte));
      chk("rd_ptr", 32'(o_ptr[cur]), m_ptr[cur]);
      step();
      chk("rd_hold", 32'({o_txv[cur], o_txd[cur]}), 32'({1'b1, e_byte}));
      if (i < n - 1) begin
        s_txreq = 1; step(); s_txreq = 0;
      end
    end
    s_mnack = 1; step(); s_mnack = 0;
    chk("rd_nack_txv", 32'(o_txv[cur]), 0);
    chk("rd_nack_busy", 32'(o_busy[cur]), 0);
    chk("rd_nack_ptr", 32'(o_ptr[cur]), m_ptr[cur]);
  endtask

  task automatic set_ptr_bytes(input int p);
    if (c_pb[cur] == 2) begin
      bq[0] = 8'h00;
      bq[1] = 8'(p);
    end else begin
      bq[0] = 8'(p);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int p;
    m_reset();
    sel(0);
    repeat (3) @(posedge clk);
    #1;
    for (int g = 0; g < 3; g++) begin
      chk("reset_outputs", 32'({o_av[g], o_ack[g], o_txv[g], o_wpv[g], o_busy[g], o_txd[g],
                                o_ptr[g]}), 0);
    end
    rst_n = 1'b1;
    step();

    // Pointer load and burst write.
    bq[0] = 8'h10; bq[1] = 8'hA1; bq[2] = 8'hA2; bq[3] = 8'hA3;
    wr_txn(4, 1);
    chk("t1_ptr", 32'(o_ptr[0]), 32'h13);

    // Pointer set, repeated START, current-address burst read.
    bq[0] = 8'h10;
    wr_txn(1, 0);
    rd_txn(3);
    chk("t2_ptr", 32'(o_ptr[0]), 32'h13);

    // Wrap at the end of the array, then read both bytes back.
    bq[0] = 8'h7F; bq[1] = 8'h55; bq[2] = 8'h66;
    wr_txn(3, 1);
    chk("t3_wrap_ptr", 32'(o_ptr[0]), 32'h01);
    bq[0] = 8'h7F;
    wr_txn(1, 0);
    rd_txn(2);

    // Saturating instance: second byte NACKs, reads past the end return 0xFF.
    sel(1);
    bq[0] = 8'h7F; bq[1] = 8'h55; bq[2] = 8'h66;
    wr_txn(3, 1);
    chk("t3_sat_ptr", 32'(o_ptr[1]), 32'h7F);
    bq[0] = 8'h7E;
    wr_txn(1, 0);
    rd_txn(3);
    bq[0] = 8'h00;
    wr_txn(1, 0);
    rd_txn(1);

    // Write-protect window.
    sel(0);
    s_wp = 1;
    bq[0] = 8'h0E; bq[1] = 8'h11; bq[2] = 8'h22;
    wr_txn(3, 1);
    chk("t4_wp_ptr", 32'(o_ptr[0]), 32'h0E);
    s_wp = 0;
    wr_txn(3, 1);
    bq[0] = 8'h0E;
    wr_txn(1, 0);
    rd_txn(2);

    // Two-byte pointer: out of range, in range, and aborted pointer.
    sel(2);
    bq[0] = 8'h00; bq[1] = 8'h80;
    wr_txn(2, 1);
    chk("t5_oor_ptr", 32'(o_ptr[2]), 32'h00);
    bq[0] = 8'h00; bq[1] = 8'h05; bq[2] = 8'hC3;
    wr_txn(3, 1);
    chk("t5_ptr", 32'(o_ptr[2]), 32'h06);
    bq[0] = 8'h00;
    wr_txn(1, 1);
    bq[0] = 8'h00; bq[1] = 8'h05;
    wr_txn(2, 0);
    rd_txn(1);

    // STOP coincident with a data byte: byte dropped. Then a byte while idle is ignored.
    sel(0);
    bq[0] = 8'h40;
    wr_txn(1, 0);
    s_stop = 1; s_rxv = 1; s_rxd = 8'h99; step(); s_stop = 0; s_rxv = 0;
    m_phase[cur] = 0;
    chk("t6_stop_rx_av", 32'(o_av[0]), 0);
    chk("t6_stop_busy", 32'(o_busy[0]), 0);
    send_byte(8'h77);
    bq[0] = 8'h40;
    wr_txn(1, 0);
    rd_txn(1);

    // Randomised write/read transfers across all instances.
    for (int it = 0; it < 24; it++) begin
      sel(int'($urandom_range(0, 2)));
      s_wp = 1'($urandom_range(0, 1));
      if (c_pb[cur] == 2) begin
        bq[0] = ($urandom_range(0, 4) == 0) ? 8'($urandom_range(1, 255)) : 8'h00;
        bq[1] = 8'($urandom_range(0, 140));
        n = 2;
      end else begin
        bq[0] = 8'($urandom_range(0, 140));
        n = 1;
      end
      for (int d = 0; d < int'($urandom_range(1, 4)); d++) begin
        bq[n] = 8'($urandom);
        n++;
      end
      wr_txn(n, 1);
      p = ($urandom_range(0, 1) == 1) ? int'($urandom_range(120, 127))
                                      : int'($urandom_range(0, 127));
      set_ptr_bytes(p);
      wr_txn(c_pb[cur], 0);
      rd_txn(int'($urandom_range(1, 3)));
    end
    s_wp = 0;

    // Asynchronous reset during a burst read.
    sel(0);
    bq[0] = 8'h10; bq[1] = 8'h5A;
    wr_txn(2, 0);
    do_start();
    s_amr = 1; step(); s_amr = 0;
    step();
    step();
    chk("t6_rd_before_rst", 32'(o_txv[0]), 1);
    #3 rst_n = 1'b0;
    #1;
    chk("t6_rst_txv", 32'(o_txv[0]), 0);
    chk("t6_rst_ptr", 32'(o_ptr[0]), 0);
    chk("t6_rst_busy", 32'(o_busy[0]), 0);
    m_reset();
    #2 rst_n = 1'b1;
    step();
    bq[0] = 8'h10;
    wr_txn(1, 0);
    rd_txn(1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
